// File: rtl/score_pkg.sv
// Shared types and constants for the score keeper: FSM states, BCD digits,
// seven-segment lookup and a BCD magnitude compare.
package score_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_e;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Common-anode patterns, bit 6 = segment g, active-low.
  localparam logic [6:0] SEG_LUT [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  function automatic logic [6:0] seg_encode(input bcd_t d);
    seg_encode = (d > 4'd9) ? SEG_BLANK : SEG_LUT[d];
  endfunction

  // Three-digit BCD "a > b", most significant digit decides first.
  function automatic logic bcd_gt(input bcd_t ah, input bcd_t at, input bcd_t ao,
                                  input bcd_t bh, input bcd_t bt, input bcd_t bo);
    if (ah != bh) return ah > bh;
    if (at != bt) return at > bt;
    return ao > bo;
  endfunction

endpackage

// File: rtl/bcd_counter3.sv
// Three-digit BCD up-counter that saturates at MAX_SCORE; clear wins over enable.
module bcd_counter3
  import score_pkg::*;
#(
  parameter int MAX_SCORE = 999
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output bcd_t ones_o,
  output bcd_t tens_o,
  output bcd_t hund_o
);

  localparam bcd_t MAX_H = bcd_t'(MAX_SCORE / 100);
  localparam bcd_t MAX_T = bcd_t'((MAX_SCORE / 10) % 10);
  localparam bcd_t MAX_O = bcd_t'(MAX_SCORE % 10);

  bcd_t ones_q, tens_q, hund_q;
  bcd_t ones_d, tens_d, hund_d;
  logic at_max;

  assign at_max = (hund_q == MAX_H) && (tens_q == MAX_T) && (ones_q == MAX_O);

  always_comb begin
    ones_d = ones_q;
    tens_d = tens_q;
    hund_d = hund_q;
    if (clr_i) begin
      ones_d = '0;
      tens_d = '0;
      hund_d = '0;
    end else if (en_i && !at_max) begin
      if (ones_q == 4'd9) begin
        ones_d = '0;
        if (tens_q == 4'd9) begin
          tens_d = '0;
          hund_d = hund_q + 4'd1;
        end else begin
          tens_d = tens_q + 4'd1;
        end
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ones_q <= '0;
      tens_q <= '0;
      hund_q <= '0;
    end else begin
      ones_q <= ones_d;
      tens_q <= tens_d;
      hund_q <= hund_d;
    end
  end

  assign ones_o = ones_q;
  assign tens_o = tens_q;
  assign hund_o = hund_q;

endmodule

// File: rtl/score_keeper.sv
// Game score / high-score tracker: counts rows while running, freezes and
// blinks the final score when the run ends, and drives the six HEX displays.
module score_keeper
  import score_pkg::*;
#(
  parameter int BLINK_DIV = 24,
  parameter int MAX_SCORE = 999
) (
  input  logic       CLK,
  input  logic       NOT_RST,
  input  logic       RUNen,
  input  logic       ENDen,
  input  logic       rowTick,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5,
  output logic       newHigh,
  output state_e     dbg_state_o
);

  localparam logic [BLINK_DIV:0] BLINK_ONE = 1;

  state_e state_q, state_d;
  logic   run_dly_q, was_over_q, newhigh_q, newhigh_d;
  logic   run_rise, cnt_clr, cnt_en, over_entry, score_blank, new_best;
  logic [BLINK_DIV:0] blink_q;
  bcd_t   sc_o, sc_t, sc_h;
  bcd_t   hi_o_q, hi_t_q, hi_h_q;
  logic [6:0] hex_q [6];
  logic [6:0] hex_d [6];

  assign run_rise = RUNen && !run_dly_q;

  always_ff @(posedge CLK or negedge NOT_RST) begin
    if (!NOT_RST) begin
      state_q    <= IDLE;
      run_dly_q  <= 1'b0;
      was_over_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_dly_q  <= RUNen;
      was_over_q <= (state_q == OVER);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (RUNen && !ENDen) state_d = RUN;
      RUN:  if (ENDen) state_d = OVER;
      OVER: begin
        if (run_rise && !ENDen)     state_d = RUN;
        else if (!RUNen && !ENDen)  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The score register already holds any coincident final tick on the first
  // OVER cycle, so comparing there sees the incremented value.
  always_comb begin
    cnt_clr     = (state_q == IDLE) || ((state_q == OVER) && (state_d == RUN));
    cnt_en      = (state_q == RUN) && rowTick;
    over_entry  = (state_q == OVER) && !was_over_q;
    score_blank = (state_q == OVER) && blink_q[BLINK_DIV];
  end

  bcd_counter3 #(.MAX_SCORE(MAX_SCORE)) u_score (
    .clk_i  (CLK),
    .rst_ni (NOT_RST),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .ones_o (sc_o),
    .tens_o (sc_t),
    .hund_o (sc_h)
  );

  assign new_best = bcd_gt(sc_h, sc_t, sc_o, hi_h_q, hi_t_q, hi_o_q);

  always_comb begin
    newhigh_d = newhigh_q;
    if ((state_q == OVER) && (state_d != OVER)) newhigh_d = 1'b0;
    else if (over_entry && new_best)            newhigh_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge NOT_RST) begin
    if (!NOT_RST) begin
      hi_o_q    <= '0;
      hi_t_q    <= '0;
      hi_h_q    <= '0;
      newhigh_q <= 1'b0;
      blink_q   <= '0;
    end else begin
      if (over_entry && new_best) begin
        hi_o_q <= sc_o;
        hi_t_q <= sc_t;
        hi_h_q <= sc_h;
      end
      newhigh_q <= newhigh_d;
      blink_q   <= blink_q + BLINK_ONE;
    end
  end

  always_comb begin
    hex_d[0] = score_blank ? SEG_BLANK : seg_encode(sc_o);
    hex_d[1] = score_blank ? SEG_BLANK : seg_encode(sc_t);
    hex_d[2] = score_blank ? SEG_BLANK : seg_encode(sc_h);
    hex_d[3] = seg_encode(hi_o_q);
    hex_d[4] = seg_encode(hi_t_q);
    hex_d[5] = seg_encode(hi_h_q);
  end

  always_ff @(posedge CLK or negedge NOT_RST) begin
    if (!NOT_RST) begin
      for (int i = 0; i < 6; i++) hex_q[i] <= SEG_LUT[0];
    end else begin
      for (int i = 0; i < 6; i++) hex_q[i] <= hex_d[i];
    end
  end

  assign HEX0        = hex_q[0];
  assign HEX1        = hex_q[1];
  assign HEX2        = hex_q[2];
  assign HEX3        = hex_q[3];
  assign HEX4        = hex_q[4];
  assign HEX5        = hex_q[5];
  assign newHigh     = newhigh_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/score_keeper.md
# score_keeper

Game score and high-score tracker for the asteroid-avoider design. It counts scrolled asteroid rows while the run sequence is active, freezes the score when the run ends, and keeps the best score seen since power-up. It drives the six HEX displays that the top level currently blanks. It sits downstream of `runSequence` (consumes `RUNen`, `ENDen` and a row-scroll pulse) and in parallel with `pixelSel`.

## Interface
Parameters:
- `BLINK_DIV`, default 24: in OVER, the final score blinks with period 2^(BLINK_DIV+1) clocks (about 0.67 s at 50 MHz).
- `MAX_SCORE`, default 999: saturation value; must be ≤ 999.

Ports:
- `CLK`  in  1  system clock, CLOCK_50.
- `NOT_RST`  in  1  reset. **Asynchronous, active-low.**
- `RUNen`  in  1  level; high while the run sequence is active.
- `ENDen`  in  1  level; high once the end sequence is enabled.
- `rowTick`  in  1  single-cycle pulse, one per asteroid row scrolled past the player.
- `HEX0`..`HEX2`  out  7 each  current score (ones, tens, hundreds); active-low segments, bit 6 = segment g.
- `HEX3`..`HEX5`  out  7 each  high score (ones, tens, hundreds); same encoding.
- `newHigh`  out  1  high in OVER when the last game set a new high score.

## Operation
State machine, three states:
- IDLE (reset state):
  - score = 0.
  - Go to RUN when `RUNen` = 1 and `ENDen` = 0.
- RUN:
  - Each `rowTick` adds 1 to the score. The score saturates at `MAX_SCORE`.
  - Go to OVER when `ENDen` = 1.
- OVER:
  - Score is frozen.
  - On the entry cycle, if score > high, then high ← score and `newHigh` ← 1.
  - Score digits blink using bit `BLINK_DIV` of a free-running counter: blank (7'h7F) while the bit is 1.
  - Return to RUN, with score cleared and `newHigh` cleared, on a `RUNen` rising edge while `ENDen` = 0.
  - Go to IDLE when both `RUNen` and `ENDen` are low.

Arithmetic and display:
- Score and high are held as 3-digit BCD.
- An increment carries ones→tens→hundreds. At 9 the ones digit wraps to 0 and carries.
- The comparison is a BCD magnitude compare, hundreds digit first.
- High-score digits never blink.
- Segment codes are standard common-anode patterns: 0 = 7'b1000000, 1 = 7'b1111001, … 9 = 7'b0010000.

## Timing
- Reset, while `NOT_RST` = 0:
  - state = IDLE, score = high = 0, blink counter = 0, `newHigh` = 0.
  - All HEX outputs = 7'b1000000 ("0"), applied immediately (asynchronous).
- Latency:
  - `rowTick` sampled at edge n updates the score register at edge n.
  - HEX outputs are registered, so the new digit is visible after edge n+1.
- `rowTick` and `ENDen` in the same cycle while in RUN: the tick counts, the state moves to OVER, and the high-score compare uses the incremented score.
- `rowTick` outside RUN is ignored.
- Saturation: at 999, further ticks leave the score at 999 and no digit wraps.
- Rising-edge detection of `RUNen` uses a one-flop delayed copy, which is cleared by reset.
- Reset asserted mid-RUN: all state, including high, clears immediately. The first clock after release is in IDLE.

## Structure
- Package `score_pkg`:
  - state enum {IDLE, RUN, OVER}.
  - `logic [3:0]` BCD digit typedef.
  - 10-entry segment lookup constant and the `SEG_BLANK` constant.
- Sub-module `bcd_counter3`: 3-digit saturating BCD incrementer with synchronous clear and enable.
- The top holds the FSM, high-score register and compare, blink divider, and the output registers with segment encoding.

## Test plan
1. **Reset.** Hold `NOT_RST` = 0 mid-clock → all HEX = 7'b1000000 and `newHigh` = 0 without waiting for a clock edge.
2. **Counting.** RUN, 12 `rowTick` pulses → HEX0 = "2" (7'b0100100), HEX1 = "1", HEX2 = "0". Each update appears one cycle after the tick edge.
3. **End of run.** 37 ticks, then `ENDen` = 1 → score frozen at 037, HEX3..5 show 037, `newHigh` = 1, HEX0..2 toggle blank/digits with period 2^(BLINK_DIV+1). Use `BLINK_DIV` = 3 in the bench.
4. **New game.** New game (`RUNen` edge with `ENDen` = 0), 20 ticks, end → score 020, high stays 037, `newHigh` = 0.
5. **Saturation.** 1005 ticks in RUN → score 999 and stays there. A tick coincident with `ENDen` at score 998 → final score 999, high = 999.
6. **Reset mid-run.** Reset mid-RUN at score 055 → score and high = 000. Ticks after release are ignored until `RUNen` is seen while in IDLE.
